mem_bus_arbiter: RTL



---
 rtl/mem_bus_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter sharing one memory port between the CPU
// path (requester 0) and the loader/debug port (requester 1), with access timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last, last_nxt;
  logic              sel, sel_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, err_nxt;
  logic              mem_req_nxt, mem_we_nxt;
  logic [31:0]       rdata_nxt, mem_addr_nxt, mem_wdata_nxt;

  logic any_req_c;
  logic win_c;
  logic timeout_hit_c;

  // On a tie the requester that was not served last wins; otherwise the lone requester
  assign any_req_c     = req0 | req1;
  assign win_c         = (req0 & req1) ? ~last : req1;
  assign timeout_hit_c = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req_c) state_nxt = BUSY;
      BUSY:    if (mem_ready || timeout_hit_c) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    last_nxt      = last;
    sel_nxt       = sel;
    cnt_nxt       = cnt;
    gnt0_nxt      = gnt0;
    gnt1_nxt      = gnt1;
    done0_nxt     = done0;
    done1_nxt     = done1;
    err_nxt       = err;
    rdata_nxt     = rdata;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (any_req_c) begin
          sel_nxt       = win_c;
          cnt_nxt       = '0;
          gnt0_nxt      = ~win_c;
          gnt1_nxt      = win_c;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = win_c ? we1 : we0;
          mem_addr_nxt  = win_c ? addr1 : addr0;
          mem_wdata_nxt = win_c ? wdata1 : wdata0;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (!mem_we) rdata_nxt = mem_rdata;
          err_nxt     = 1'b0;
          mem_req_nxt = 1'b0;
          done0_nxt   = ~sel;
          done1_nxt   = sel;
        end else if (timeout_hit_c) begin
          rdata_nxt   = '0;
          err_nxt     = 1'b1;
          mem_req_nxt = 1'b0;
          done0_nxt   = ~sel;
          done1_nxt   = sel;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        // No arbitration here, so a request still high during done is not re-granted
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        last_nxt  = sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last      <= 1'b1;
      sel       <= 1'b0;
      cnt       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      last      <= last_nxt;
      sel       <= sel_nxt;
      cnt       <= cnt_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      err       <= err_nxt;
      rdata     <= rdata_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule
